// File: rtl/id_branch_front_pkg.sv
// Shared decode definitions for the ID-stage branch front end.
// Purely declarative: no logic, no latency.
// Used by the stage and by any future EX-side branch resolver.
package id_branch_front_pkg;

  // LoongArch control-transfer major opcodes, inst[31:26]
  localparam logic [5:0] OP_B    = 6'b010100;
  localparam logic [5:0] OP_BL   = 6'b010101;
  localparam logic [5:0] OP_BEQ  = 6'b010110;
  localparam logic [5:0] OP_BNE  = 6'b010111;
  localparam logic [5:0] OP_BLT  = 6'b011000;
  localparam logic [5:0] OP_BGE  = 6'b011001;
  localparam logic [5:0] OP_BLTU = 6'b011010;
  localparam logic [5:0] OP_BGEU = 6'b011011;
  localparam logic [5:0] OP_JIRL = 6'b010011;

  // Value held in the PC register while the stage is empty after reset
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  // Link register written by BL
  localparam logic [4:0] LINK_REG_RA = 5'd1;

  typedef enum logic [3:0] {
    BK_NONE,
    BK_B,
    BK_BL,
    BK_BEQ,
    BK_BNE,
    BK_BLT,
    BK_BGE,
    BK_BLTU,
    BK_BGEU,
    BK_JIRL
  } br_kind_t;

  // Map a major opcode to its branch kind; everything unknown is BK_NONE
  function automatic br_kind_t decode_kind(input logic [5:0] op);
    br_kind_t k;
    case (op)
      OP_B:    k = BK_B;
      OP_BL:   k = BK_BL;
      OP_BEQ:  k = BK_BEQ;
      OP_BNE:  k = BK_BNE;
      OP_BLT:  k = BK_BLT;
      OP_BGE:  k = BK_BGE;
      OP_BLTU: k = BK_BLTU;
      OP_BGEU: k = BK_BGEU;
      OP_JIRL: k = BK_JIRL;
      default: k = BK_NONE;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/id_branch_front_if.sv
// Fetch-to-decode handshake plus the redirect path back into fetch.
// Combinational wires only; the decode stage registers on its side.
// allow_in is the backpressure; flush/target redirect fetch for one cycle.
interface id_branch_front_if;
  logic        if_ready_go;
  logic        if_allow_in;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        br_flush;
  logic [31:0] br_target;

  // fetch side
  modport master (
    output if_ready_go, if_inst, if_pc,
    input  if_allow_in, br_flush, br_target
  );

  // decode side
  modport slave (
    input  if_ready_go, if_inst, if_pc,
    output if_allow_in, br_flush, br_target
  );
endinterface

// File: rtl/id_branch_front_br_cond_unit.sv
// Branch condition evaluator: decides taken from opcode and two operands.
// Purely combinational, zero latency.
// No handshake; callers qualify the result with their own valid.
module br_cond_unit
  import id_branch_front_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [31:0] rj_value,
  input  logic [31:0] rkd_value,
  output logic        taken
);

  logic eq;
  logic lt_s;
  logic lt_u;

  assign eq   = (rj_value == rkd_value);
  assign lt_s = ($signed(rj_value) < $signed(rkd_value));
  assign lt_u = (rj_value < rkd_value);

  // Unconditional transfers are always taken; non-branches never are
  always_comb begin
    taken = 1'b0;
    case (opcode)
      OP_B, OP_BL, OP_JIRL: taken = 1'b1;
      OP_BEQ:               taken = eq;
      OP_BNE:               taken = ~eq;
      OP_BLT:               taken = lt_s;
      OP_BGE:               taken = ~lt_s;
      OP_BLTU:              taken = lt_u;
      OP_BGEU:              taken = ~lt_u;
      default:              taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/id_branch_front.sv
// Decode front end: latches fetch's inst/PC, resolves branches, redirects fetch.
// One cycle from fire_in to id_valid; flush/target are combinational off stage state.
// allow_in drops while the held instruction cannot leave (operands or EX stall).
module id_branch_front
  import id_branch_front_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  id_branch_front_if.slave     fe,
  output logic [4:0]           rf_raddr1,
  output logic [4:0]           rf_raddr2,
  input  logic [31:0]          rj_value,
  input  logic [31:0]          rkd_value,
  input  logic                 operands_ready,
  input  logic                 ex_allow_in,
  output logic                 id_ready_go,
  output logic                 id_valid,
  output logic [31:0]          id_pc,
  output logic [31:0]          id_inst,
  output logic                 link_we,
  output logic [4:0]           link_dest,
  output logic [31:0]          link_value
);

  logic        fire_in;
  logic        fire_out;
  logic        taken;
  logic [5:0]  opcode;
  br_kind_t    kind;
  logic [31:0] offs16_ext;
  logic [31:0] offs26_ext;
  logic [31:0] target;

  // Handshake: a slot frees up in the same cycle the current occupant leaves
  assign id_ready_go    = id_valid & operands_ready;
  assign fire_out       = id_ready_go & ex_allow_in;
  assign fe.if_allow_in = ~id_valid | fire_out;
  assign fire_in        = fe.if_ready_go & fe.if_allow_in;

  // Stage register: new arrival has priority over departure so back-to-back flow keeps valid high
  always_ff @(posedge clk) begin
    if (reset) begin
      id_valid <= 1'b0;
      id_pc    <= RESET_PC;
      id_inst  <= 32'h0;
    end else if (fire_in) begin
      id_valid <= 1'b1;
      id_pc    <= fe.if_pc;
      id_inst  <= fe.if_inst;
    end else if (fire_out) begin
      id_valid <= 1'b0;
    end
  end

  assign opcode    = id_inst[31:26];
  assign kind      = decode_kind(opcode);
  assign rf_raddr1 = id_inst[9:5];
  assign rf_raddr2 = id_inst[4:0];

  // Word offsets scaled to bytes and sign-extended
  assign offs16_ext = {{14{id_inst[25]}}, id_inst[25:10], 2'b00};
  assign offs26_ext = {{4{id_inst[9]}}, id_inst[9:0], id_inst[25:10], 2'b00};

  br_cond_unit u_br_cond (
    .opcode    (opcode),
    .rj_value  (rj_value),
    .rkd_value (rkd_value),
    .taken     (taken)
  );

  // Target adder: JIRL bases off rj, B/BL use the long offset, the rest PC-relative short offset
  always_comb begin
    target = id_pc + offs16_ext;
    case (kind)
      BK_B, BK_BL: target = id_pc + offs26_ext;
      BK_JIRL:     target = rj_value + offs16_ext;
      default:     target = id_pc + offs16_ext;
    endcase
  end

  // Redirect only as the branch leaves, so a stalled branch never flushes twice
  assign fe.br_flush  = id_valid & fire_out & taken;
  assign fe.br_target = target;

  // Link write-back for calls: BL always links to ra, JIRL to its rd field
  always_comb begin
    link_we   = 1'b0;
    link_dest = id_inst[4:0];
    case (kind)
      BK_BL: begin
        link_we   = id_valid;
        link_dest = LINK_REG_RA;
      end
      BK_JIRL: begin
        link_we   = id_valid;
        link_dest = id_inst[4:0];
      end
      default: begin
        link_we   = 1'b0;
        link_dest = id_inst[4:0];
      end
    endcase
  end

  assign link_value = id_pc + 32'd4;

endmodule

// File: doc/id_branch_front.md
# id_branch_front

Decode-stage front end that is the receiving side of the fetch-to-decode handshake. It latches the instruction/PC pair offered by fetch and produces the `allow_in` backpressure. It resolves LoongArch control-transfer instructions and drives the one-cycle `flush`/`newpc` redirect back into fetch. It hands the latched instruction to EX under an equivalent valid/allow handshake.

## Interface
- No parameters.
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- if_ready_go  in  1  fetch offers a valid instruction
- if_allow_in  out  1  this stage can accept this cycle
- if_inst  in  32  offered instruction word
- if_pc  in  32  offered PC
- br_flush  out  1  redirect fetch this cycle (combinational)
- br_target  out  32  redirect PC, meaningful only while br_flush=1
- rf_raddr1  out  5  rj field, inst[9:5]
- rf_raddr2  out  5  rd field, inst[4:0]
- rj_value  in  32  forwarded rj operand
- rkd_value  in  32  forwarded rd operand
- operands_ready  in  1  hazard unit: both operands valid
- ex_allow_in  in  1  EX can accept
- id_ready_go  out  1  id_valid & operands_ready
- id_valid  out  1  stage holds an instruction
- id_pc  out  32  latched PC
- id_inst  out  32  latched instruction
- link_we  out  1  BL or JIRL in stage
- link_dest  out  5  BL→5'd1, JIRL→rd
- link_value  out  32  id_pc+4

## Operation
- Define `fire_in = if_ready_go & if_allow_in` and `fire_out = id_ready_go & ex_allow_in`.
- `if_allow_in` equals `~id_valid | fire_out`.
- On fire_in: id_pc←if_pc, id_inst←if_inst, id_valid←1. Otherwise, on fire_out: id_valid←0. Otherwise hold.
- Decode uses inst[31:26]:
  - 010100 B
  - 010101 BL
  - 010110 BEQ
  - 010111 BNE
  - 011000 BLT
  - 011001 BGE
  - 011010 BLTU
  - 011011 BGEU
  - 010011 JIRL
  - anything else is not a branch.
- Offsets:
  - offs16 = inst[25:10].
  - offs26 = {inst[9:0], inst[25:10]}.
  - Both are shifted left 2 and sign-extended to 32 bits.
- Targets:
  - B/BL: id_pc + sext(offs26<<2).
  - Conditional branches: id_pc + sext(offs16<<2).
  - JIRL: rj_value + sext(offs16<<2).
  - All additions wrap modulo 2^32.
- Conditions compare rj_value against rkd_value:
  - EQ and NE.
  - signed LT and GE.
  - unsigned LTU and GEU.
  - B, BL and JIRL are always taken.
- `br_flush = id_valid & fire_out & taken`. Redirect happens exactly once, in the cycle the branch leaves to EX. It never asserts while stalled on operands.
- In a br_flush cycle, fetch withholds its wrong-path instruction (its ready_go is gated by flush), so fire_in cannot occur. The stage goes empty.
- Not-taken branches and non-branches never assert br_flush. br_target is don't-care then; drive it to the computed target.

## Timing
- Reset values:
  - id_valid=0, id_pc=0, id_inst=0.
  - Hence if_allow_in=1, br_flush=0, id_ready_go=0, link_we=0.
- Latency is one cycle from fire_in to id_valid/id_inst visible.
- Simultaneous fire_out and fire_in: the new instruction replaces the old; id_valid stays 1.
- If operands_ready=0 with id_valid=1 (stall): if_allow_in=0 and registers hold.
- If ex_allow_in=0: same as a stall; br_flush stays 0.
- br_flush and br_target are combinational from registered state plus forwarded operands. No registered delay is allowed.
- Reset mid-stall or mid-branch drops the instruction with no flush.

## Structure
- Shared package holds:
  - opcode constants (OP_B, OP_BL, OP_BEQ … OP_JIRL, 6-bit);
  - the reset PC constant;
  - a branch-kind enum.
- One sub-module is natural: `br_cond_unit`. It takes opcode, rj_value and rkd_value and returns taken. It is purely combinational and shared with a future EX-side resolver.

## Test plan
- After reset, `if_ready_go=1, if_pc=0x1c000000, if_inst=0x02800000`, with operands_ready=1 and ex_allow_in=1 → next cycle id_valid=1 and id_pc=0x1c000000; br_flush stays 0.
- BEQ r1,r2,+8 (`0x58000822`) at pc 0x1c000000 with rj_value=rkd_value=5 → br_flush=1 for exactly one cycle, br_target=0x1c000008. Next cycle id_valid=0.
- Same BEQ with rj_value=5, rkd_value=6 → br_flush never asserts.
- BLT with rj_value=0xFFFFFFFF, rkd_value=1 → taken. BLTU with the same operands → not taken.
- B −4 (`0x53FFFFFF`) at 0x1c000000 held with operands_ready=0 for 3 cycles:
  - br_flush=0 and if_allow_in=0 throughout the stall;
  - on release, a single flush with br_target=0x1bfffffc.
- JIRL r1,r5,0 (`0x4C0000A1`) with rj_value=0x1c000100 → br_target=0x1c000100, link_we=1, link_dest=1, link_value=pc+4. Assert reset in the following cycle → id_valid=0.
